fifo_sync_param: RTL
====================

// Module: fifo_sync_param
// PURPOSE
//  Single-clock, parametrised FIFO; successor to the dual-clock FIFO for same-clock-domain AMBA
//  datapaths (bridge buffers, AHB/APB request queues). Adds selectable show-ahead/registered
//  read mode, fill level, programmable almost-full/almost-empty, sticky overflow/underflow,
//  synchronous flush. No gray-code crossing; pointers and level are local.
// PARAMETERS
//  data_width  16   data bits per entry
//  addr_width  8    log2 of depth; data_depth = 2**addr_width
//  show_ahead  1    1: dout shows head entry while !empty; 0: dout registered, 1-cycle read latency
//  af_thresh   248  almost_full asserts when level >= af_thresh (1..data_depth)
//  ae_thresh   8    almost_empty asserts when level <= ae_thresh (0..data_depth-1)
// PORTS
//  clk           in   1             clock, all logic on rising edge
//  rst_n         in   1             asynchronous reset, active low
//  clr           in   1             synchronous flush, active high
//  wr_en         in   1             write request
//  din           in   data_width    write data
//  rd_en         in   1             read request (show_ahead=1: acknowledge/pop head)
//  dout          out  data_width    read data
//  valid         out  1             dout holds a valid entry
//  empty         out  1             level == 0
//  full          out  1             level == data_depth
//  almost_empty  out  1             level <= ae_thresh
//  almost_full   out  1             level >= af_thresh
//  level         out  addr_width+1  current entry count, 0..data_depth
//  overflow      out  1             sticky: write attempted while full
//  underflow     out  1             sticky: read attempted while empty
// BEHAVIOUR
//  Reset (rst_n low, async): wr/rd pointers=0, level=0, empty=1, full=0, almost_empty=1,
//   almost_full=0, overflow=0, underflow=0, valid=0, registered dout=0. Storage array not reset.
//  Accept: wr_acc = wr_en & ~full; rd_acc = rd_en & ~empty; both from registered state of
//   this cycle. Write while full is dropped (even with simultaneous rd_acc) -> overflow<=1.
//   Read while empty dropped (even with simultaneous write) -> underflow<=1.
//  wr_acc: mem[wr_ptr]<=din, wr_ptr++. rd_acc: rd_ptr++. Pointers addr_width+1 bits, wrap at
//   2**(addr_width+1); RAM index = low addr_width bits.
//  level: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither. Flags are
//   combinational from registered level, so they change the cycle after the accepted op.
//  show_ahead=1: dout = mem[rd_addr] combinationally; valid = ~empty; dout don't-care when empty.
//   Entry written at edge N visible on dout after edge N (first-word fall-through, 1 cycle).
//  show_ahead=0: on rd_acc, dout<=mem[rd_addr], valid<=1 next cycle; otherwise valid<=0, dout
//   holds last value (not zeroed).
//  clr: highest priority after reset; pointers, level, overflow, underflow, valid -> 0 next edge;
//   wr_en/rd_en that cycle ignored; registered dout holds.
//  overflow/underflow clear only via rst_n or clr.
//  Reset mid-operation: all state drops immediately; stored data discarded logically.
// TESTING
//  1. Reset, write 0x0001..0x0100 (256 wr) -> full=1 after 256th edge, level=256, almost_full
//     from level 248; 257th write -> overflow=1, level stays 256, mem unchanged.
//  2. show_ahead=1: single write 0xA5A5 -> next cycle valid=1, dout=0xA5A5; rd_en 1 cycle ->
//     empty=1, valid=0 next cycle.
//  3. show_ahead=0: write 0x1234, 0x5678; rd_en 2 cycles -> valid high 2 cycles starting edge
//     after first rd_en, dout 0x1234 then 0x5678, then holds 0x5678 with valid=0.
//  4. Level=5, wr_en&rd_en every cycle for 600 cycles (pointer wrap) -> level stays 5, data
//     order preserved, no flag change.
//  5. Empty, rd_en with wr_en same cycle -> underflow=1, level=1, data readable next cycle;
//     full, wr_en&rd_en -> read accepted, write dropped, overflow=1, level=255.
//  6. Level=100, overflow=1, assert clr with wr_en -> next cycle level=0, empty=1, overflow=0;
//     async rst_n pulse mid-burst -> all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if
//   Handshake/data bundle for fifo_sync_param. The producer/consumer side
//   uses the master modport, and the FIFO itself uses the slave modport.
//   Signals:
//     clr          flush request, active high (master -> fifo)
//     wr_en, din   write request and write data (master -> fifo)
//     rd_en        read request / head pop (master -> fifo)
//     dout, valid  read data and its qualifier (fifo -> master)
//     empty, full, almost_empty, almost_full, level
//                  occupancy status (fifo -> master)
//     overflow, underflow
//                  sticky error flags (fifo -> master)
interface fifo_sync_param_if #(
  parameter int data_width = 16,
  parameter int addr_width = 8
);
  logic                  clr;
  logic                  wr_en;
  logic [data_width-1:0] din;
  logic                  rd_en;
  logic [data_width-1:0] dout;
  logic                  valid;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [addr_width:0]   level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clr, wr_en, din, rd_en,
    input  dout, valid, empty, full, almost_empty, almost_full, level,
           overflow, underflow
  );

  modport slave (
    input  clr, wr_en, din, rd_en,
    output dout, valid, empty, full, almost_empty, almost_full, level,
           overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// fifo_sync_param
//   Single-clock parametrised FIFO. It has a selectable show-ahead
//   (first-word fall-through) or registered read port, a fill level,
//   almost-full/almost-empty thresholds, sticky overflow/underflow flags,
//   and a synchronous flush.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous reset, active low
//     bus    fifo_sync_param_if.slave (clr, wr_en, din, rd_en in;
//            dout, valid, empty, full, almost_empty, almost_full, level,
//            overflow, underflow out)
module fifo_sync_param #(
  parameter int data_width = 16,
  parameter int addr_width = 8,
  parameter bit show_ahead = 1'b1,
  parameter int af_thresh  = 248,
  parameter int ae_thresh  = 8
) (
  input logic              clk,
  input logic              rst_n,
  fifo_sync_param_if.slave bus
);

  localparam int data_depth = 1 << addr_width;

  typedef logic [addr_width:0] cnt_t;

  localparam cnt_t cnt_one    = cnt_t'(1);
  localparam cnt_t full_level = cnt_t'(data_depth);
  localparam cnt_t af_level   = cnt_t'(af_thresh);
  localparam cnt_t ae_level   = cnt_t'(ae_thresh);

  logic [data_width-1:0] mem [data_depth];

  cnt_t                  wr_ptr;
  cnt_t                  rd_ptr;
  cnt_t                  level_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  empty_int;
  logic                  full_int;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [addr_width-1:0] wr_addr;
  logic [addr_width-1:0] rd_addr;

  // Status is decoded from the registered level. Flags therefore move one
  // cycle after the operation that changed the level.
  assign empty_int = (level_q == '0);
  assign full_int  = (level_q == full_level);

  // A flush swallows any request in the same cycle. Otherwise a write to a
  // full FIFO is dropped even if a read is popping at the same edge.
  assign wr_acc = bus.wr_en & ~full_int  & ~bus.clr;
  assign rd_acc = bus.rd_en & ~empty_int & ~bus.clr;

  // Pointers carry one extra wrap bit. Only the low bits address the RAM.
  assign wr_addr = wr_ptr[addr_width-1:0];
  assign rd_addr = rd_ptr[addr_width-1:0];

  assign bus.empty        = empty_int;
  assign bus.full         = full_int;
  assign bus.almost_empty = (level_q <= ae_level);
  assign bus.almost_full  = (level_q >= af_level);
  assign bus.level        = level_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  // Pointer, level and sticky-flag state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + cnt_one;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + cnt_one;
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   level_q <= level_q + cnt_one;
        2'b01:   level_q <= level_q - cnt_one;
        default: level_q <= level_q;
      endcase
      if (bus.wr_en && full_int) begin
        overflow_q <= 1'b1;
      end
      if (bus.rd_en && empty_int) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // Storage has no reset. A reset or flush discards its contents only
  // logically, by zeroing the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_addr] <= bus.din;
    end
  end

  generate
    if (show_ahead) begin : g_show_ahead
      // The head entry is exposed directly. Its value is meaningless while
      // the FIFO is empty, which valid reflects.
      assign bus.dout  = mem[rd_addr];
      assign bus.valid = ~empty_int;
    end else begin : g_registered
      logic [data_width-1:0] dout_q;
      logic                  valid_q;

      // Each accepted read loads the head into dout_q and pulses valid for
      // one cycle. Between reads, dout_q keeps its last value.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else if (bus.clr) begin
          valid_q <= 1'b0;
        end else if (rd_acc) begin
          dout_q  <= mem[rd_addr];
          valid_q <= 1'b1;
        end else begin
          valid_q <= 1'b0;
        end
      end

      assign bus.dout  = dout_q;
      assign bus.valid = valid_q;
    end
  endgenerate

endmodule
